// File: rtl/forward_scoreboard.sv
// Forwarding / load-use hazard unit: tracks the last DEPTH register writes with result-latency countdowns.
// Lookup is combinational (fwd_sel/stall valid in the same cycle as src_reg); table updates one edge later.
// freeze holds the table and stall accounting; flush overrides freeze and squashes young entries.
module forward_scoreboard #(
    parameter int DEPTH       = 3,
    parameter int NSRC        = 2,
    parameter int RW          = 5,
    parameter int LW          = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int SW          = $clog2(DEPTH+1)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               issue_valid,
    input  logic               issue_wen,
    input  logic [RW-1:0]      issue_dest,
    input  logic [LW-1:0]      issue_lat,
    input  logic [NSRC*RW-1:0] src_reg,
    input  logic [NSRC-1:0]    src_used,
    input  logic               freeze,
    input  logic               flush,
    input  logic               stat_clr,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               stall,
    output logic [15:0]        stall_cycles
);

    // Entry 0 is the youngest producer, one cycle ahead of ID.
    logic [DEPTH-1:0] ent_vld;
    logic [RW-1:0]    ent_dest [DEPTH];
    logic [LW-1:0]    ent_cnt  [DEPTH];

    logic [NSRC-1:0]  hazard;
    logic             found;
    logic             advance;
    logic             take_new;

    // Per-slot search for the youngest matching producer; forward if ready, otherwise flag a hazard.
    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        found   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && src_used[i] && ent_vld[k]
                    && (src_reg[i*RW +: RW] != '0)
                    && (ent_dest[k] == src_reg[i*RW +: RW])) begin
                    found = 1'b1;
                    if (ent_cnt[k] == '0) begin
                        fwd_sel[i*SW +: SW] = SW'(k + 1);
                    end else begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Stall and shift-control decode; a flushed cycle never stalls and never issues.
    always_comb begin
        stall    = issue_valid & (|hazard) & ~flush;
        advance  = ~freeze | flush;
        take_new = issue_valid & ~stall & ~flush;
    end

    // Scoreboard shift: age every entry one slot, count latency down, insert the new producer or a bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ent_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_dest[k] <= '0;
                ent_cnt[k]  <= '0;
            end
        end else if (advance) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                // Flush squashes the wrong-path instructions that land in entries 1..FLUSH_DEPTH-1.
                ent_vld[k]  <= ent_vld[k-1] & ~(flush & (k < FLUSH_DEPTH));
                ent_dest[k] <= ent_dest[k-1];
                ent_cnt[k]  <= (ent_cnt[k-1] == '0) ? '0 : ent_cnt[k-1] - 1'b1;
            end
            // Non-writing instructions and r0 writes can never be forwarded, so store them invalid.
            ent_vld[0]  <= take_new & issue_wen & (|issue_dest);
            ent_dest[0] <= issue_dest;
            ent_cnt[0]  <= issue_lat;
        end
    end

    // Saturating stall counter; clear wins, frozen cycles are not counted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
        end else if (stat_clr) begin
            stall_cycles <= '0;
        end else if (stall && !freeze && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined datapath. It tracks the last DEPTH issued register writes in a shift-register scoreboard, each with a per-entry result-latency countdown. For every source operand of the instruction in ID, it returns the pipeline stage to forward from, or a stall request when the producer's data is not yet available. This generalises the fixed two-source, fixed-stage forwarding unit to any depth, source count and producer latency, and adds bubble insertion, freeze, flush and stall accounting.

## Interface
Parameters:
- DEPTH, 3: in-flight producer entries tracked (entry 0 = youngest, one cycle ahead of ID).
- NSRC, 2: source operands queried per cycle.
- RW, 5: register address width.
- LW, 2: latency countdown width.
- FLUSH_DEPTH, 1: entries squashed on flush, counting the inserted bubble.
- SW = $clog2(DEPTH+1): derived width of the select.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  the ID instruction moves to EX on this advance.
- issue_wen  in  1  the issuing instruction writes a register.
- issue_dest  in  RW  destination register of the issuing instruction.
- issue_lat  in  LW  advances after issue before the result can be forwarded (ALU 0, load 1).
- src_reg  in  NSRC*RW  packed source register numbers; slot i = bits [i*RW +: RW].
- src_used  in  NSRC  slot i is a real operand.
- freeze  in  1  global pipeline hold (memory wait).
- flush  in  1  branch or jump squash.
- stat_clr  in  1  synchronous clear of stall_cycles.
- fwd_sel  out  NSRC*SW  per slot: 0 = register file, k+1 = forward from entry k.
- stall  out  1  hold ID and insert a bubble.
- stall_cycles  out  16  saturating count of stalled cycles.

## Operation
- Each entry holds valid, dest (RW) and cnt (LW). An entry with issue_wen=0 or issue_dest=0 is stored invalid.
- Lookup (combinational) for slot i:
  - Match = the lowest-index valid entry k with dest == src_reg[i]. Register 0 never matches.
  - No match, or src_used[i]=0: fwd_sel=0.
  - Match with cnt==0: fwd_sel=k+1.
  - Match with cnt!=0: fwd_sel=0 and the slot is hazarded.
- stall = issue_valid & (OR of hazarded slots) & !flush.
- Advance = !freeze | flush. On advance:
  - Entry k+1 takes entry k, with cnt decremented and saturating at 0.
  - The oldest entry is dropped.
  - Entry 0 takes the new instruction when issue_valid & !stall & !flush. Otherwise it takes a bubble (valid=0).
- Flush: post-shift entries 1..FLUSH_DEPTH-1 are invalidated. Flush has priority over freeze.
- Freeze without flush: all entries hold and cnt does not decrement. stall and fwd_sel still evaluate.
- stall_cycles:
  - Priority: stat_clr > increment > hold.
  - Increments on each edge with stall & !freeze.
  - Saturates at 16'hFFFF.

## Timing
- Reset, asynchronous on nRST low: all entries invalid, cnt=0, stall_cycles=0. fwd_sel=0 and stall=0 follow immediately from the empty table.
- Lookup has zero latency. fwd_sel and stall are valid in the same cycle as src_reg.
- ALU producer, issue_lat=0: the next instruction gets fwd_sel=1 with no stall.
- Load producer, issue_lat=1: the next instruction stalls exactly 1 cycle, then gets fwd_sel=2.
- Producer latency L: stall lasts L cycles, not counting freeze cycles.
- Multiple matches: the youngest wins, even if it is not ready. That case stalls rather than forwarding stale older data.
- An entry beyond index DEPTH-1 is forgotten. The register file is assumed written by then.
- Reset asserted mid-stall: the table clears asynchronously and stall drops without waiting for a clock.

## Test plan
- Reset with nRST=0: stall=0, fwd_sel=0, stall_cycles=0. Release, then issue ADD r3 (lat 0); the next query src_reg={r3,r4} returns fwd_sel={1,0}, stall=0.
- Issue LW r5 (lat 1), then query src {r5,r0}: stall=1 for 1 cycle and stall_cycles=1. Next cycle fwd_sel={2,0} with stall=0.
- Issue ADD r7, then SUB r7, then query r7: fwd_sel=1 (youngest). With DEPTH=3, after three bubbles a query on r7 gives 0.
- LW r9, then freeze for 4 cycles with r9 queried: stall held, table frozen, stall_cycles unchanged. After release, 1 stall cycle, then fwd_sel=2.
- Issue ADD r2, then flush with FLUSH_DEPTH=2 while r2 is queried: after the edge r2 gives fwd_sel=0. src_used=0 on a matching register never stalls.
- Force 65 540 consecutive load-use stalls: stall_cycles stops at 16'hFFFF. stat_clr=1 returns it to 0 on the next edge.
